bsg_dff_en_rr_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one enabled, resettable holding register between N requesters.
- Each cycle it picks at most one valid requester, drives the register enable and data mux, and records the winner's id alongside the data.
- The held entry goes to a single consumer through a valid/yumi handshake.
- Sits between several producers and one shared pipeline-stage register.

---
 rtl/bsg_dff_arb_pkg.sv | 14 +
 rtl/bsg_dff_reset_n_en.sv | 28 ++
 rtl/bsg_dff_en_rr_arb.sv | 122 ++++++++++++
 tb/tb_bsg_dff_en_rr_arb.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/bsg_dff_arb_pkg.sv
// bsg_dff_arb_pkg: shared helpers for the round-robin holding-register arbiter.
//   id_width : width of an owner id for a given requester count (minimum 1 bit)
//   wrap_inc : advance a requester index, wrapping from els-1 back to 0
package bsg_dff_arb_pkg;

  function automatic int id_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

  function automatic int wrap_inc(input int idx, input int els);
    return (idx >= els - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bsg_dff_reset_n_en.sv
// bsg_dff_reset_n_en: register with synchronous active-low reset and load enable.
//   clk_i     : clock
//   reset_n_i : synchronous reset, active low (clears to zero)
//   en_i      : load data_i on the next posedge
//   data_i    : next value
//   data_o    : held value
module bsg_dff_reset_n_en #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_q, data_d;

  assign data_d = en_i ? data_i : data_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) data_q <= '0;
    else            data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/bsg_dff_en_rr_arb.sv
// bsg_dff_en_rr_arb: round-robin arbiter sharing one holding register between
// els_p requesters; the held entry is drained through a valid/yumi handshake.
//   clk_i     : clock
//   reset_n_i : synchronous reset, active low
//   v_i       : per-requester valid
//   data_i    : per-requester data, requester k at [k*width_p +: width_p]
//   yumi_o    : one-hot accept, high in the cycle a request is consumed
//   v_o       : holding register holds a valid entry
//   data_o    : held data
//   id_o      : index of the requester whose data is held
//   yumi_i    : consumer pops the held entry
//   lock_i    : (BSG_DFF_ARB_LOCK_EN only) keep priority on the winner
// Optional macro BSG_DFF_ARB_LOCK_EN adds lock_i for back-to-back bursts.
module bsg_dff_en_rr_arb
  import bsg_dff_arb_pkg::*;
#(
  parameter  int els_p       = 4,
  parameter  int width_p     = 16,
  localparam int id_width_lp = id_width(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [els_p-1:0]           v_i,
  input  logic [els_p*width_p-1:0]   data_i,
  output logic [els_p-1:0]           yumi_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  output logic [id_width_lp-1:0]     id_o,
`ifdef BSG_DFF_ARB_LOCK_EN
  input  logic [els_p-1:0]           lock_i,
`endif
  input  logic                       yumi_i
);

  logic [id_width_lp-1:0] ptr_q, ptr_d, ptr_inc, win_id;
  logic [width_p-1:0]     win_data;
  logic                   found, can_load, load;
  logic                   full_q, full_d;

  // Scan from the priority pointer, wrapping, and take the first valid bit.
  always_comb begin
    int idx;
    idx      = 0;
    found    = 1'b0;
    win_id   = '0;
    win_data = '0;
    for (int i = 0; i < els_p; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= els_p) idx = idx - els_p;
      if (!found && v_i[idx]) begin
        found    = 1'b1;
        win_id   = id_width_lp'(idx);
        win_data = data_i[idx*width_p +: width_p];
      end
    end
  end

  // A pop frees the slot in the same cycle, so load and pop can overlap.
  assign can_load = ~full_q | yumi_i;
  assign load     = found & can_load & reset_n_i;

  always_comb begin
    yumi_o         = '0;
    yumi_o[win_id] = load;
  end

  assign ptr_inc = id_width_lp'(wrap_inc(int'(win_id), els_p));

  // With the lock feature a locked winner keeps the pointer. The lock drops
  // by itself once the owner goes idle: the scan from ptr_q then picks
  // someone else and the pointer moves past that winner.
  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
`ifdef BSG_DFF_ARB_LOCK_EN
      if (lock_i[win_id]) ptr_d = win_id;
      else                ptr_d = ptr_inc;
`else
      ptr_d = ptr_inc;
`endif
    end
  end

  always_comb begin
    full_d = full_q;
    if (load)        full_d = 1'b1;
    else if (yumi_i) full_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      full_q <= 1'b0;
      ptr_q  <= '0;
    end else begin
      full_q <= full_d;
      ptr_q  <= ptr_d;
    end
  end

  bsg_dff_reset_n_en #(.width_p(width_p)) data_reg (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .en_i     (load),
    .data_i   (win_data),
    .data_o   (data_o)
  );

  bsg_dff_reset_n_en #(.width_p(id_width_lp)) id_reg (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .en_i     (load),
    .data_i   (win_id),
    .data_o   (id_o)
  );

  assign v_o = full_q;

  // Popping an empty register is a consumer bug; the logic tolerates it.
  a_no_pop_when_empty: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> full_q);

endmodule

// File: tb/tb_bsg_dff_en_rr_arb.sv
module tb_bsg_dff_en_rr_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  v_i;
  logic [63:0] data_i;
  logic [3:0]  yumi_o;
  logic        v_o;
  logic [15:0] data_o;
  logic [1:0]  id_o;
  logic        yumi_i;
  logic [3:0]  lock_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bsg_dff_en_rr_arb #(.els_p(4), .width_p(16)) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .v_i      (v_i),
    .data_i   (data_i),
    .yumi_o   (yumi_o),
    .v_o      (v_o),
    .data_o   (data_o),
    .id_o     (id_o),
`ifdef BSG_DFF_ARB_LOCK_EN
    .lock_i   (lock_i),
`endif
    .yumi_i   (yumi_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] d, input logic [1:0] id);
    chk({tag, "_v"},  {31'd0, v_o}, {31'd0, v});
    chk({tag, "_d"},  {16'd0, data_o}, {16'd0, d});
    chk({tag, "_id"}, {30'd0, id_o}, {30'd0, id});
  endtask

  initial begin
    reset_n = 1'b0;
    v_i     = 4'b1111;
    data_i  = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
    yumi_i  = 1'b0;
    lock_i  = 4'b0000;

    // reset: requests pending but never accepted
    tick();
    #1 chk("rst_yumi", {28'd0, yumi_o}, 32'h0);
    tick();
    chk_out("rst", 1'b0, 16'h0000, 2'd0);

    // idle after reset
    reset_n = 1'b1;
    v_i     = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      #1 chk("idle_yumi", {28'd0, yumi_o}, 32'h0);
      tick();
      chk_out("idle", 1'b0, 16'h0000, 2'd0);
    end

    // full-throughput rotation: grants 0,1,2,3,0
    v_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      yumi_i = (k > 0);
      #1 chk("rr_yumi", {28'd0, yumi_o}, 32'd1 << (k % 4));
      tick();
      chk_out("rr", 1'b1, 16'h00A0 + 16'(k % 4), 2'(k % 4));
    end
    // now full, id 0, ptr 1

    // single requester 2, pop of the old entry overlaps the load
    v_i    = 4'b0100;
    data_i = {16'h00A3, 16'h1234, 16'h00A1, 16'h00A0};
    yumi_i = 1'b1;
    #1 chk("one_yumi", {28'd0, yumi_o}, 32'h4);
    tick();
    chk_out("one", 1'b1, 16'h1234, 2'd2);

    // consumer stalls: requester 2 waits, entry held
    yumi_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1 chk("stall_yumi", {28'd0, yumi_o}, 32'h0);
      tick();
      chk_out("stall", 1'b1, 16'h1234, 2'd2);
    end

    // pop re-grants requester 2 in the same cycle
    yumi_i = 1'b1;
    #1 chk("regrant_yumi", {28'd0, yumi_o}, 32'h4);
    tick();
    chk_out("regrant", 1'b1, 16'h1234, 2'd2);

    // pop with no requests: empties, data stale
    v_i = 4'b0000;
    #1 chk("drain_yumi", {28'd0, yumi_o}, 32'h0);
    tick();
    chk_out("drain", 1'b0, 16'h1234, 2'd2);
    yumi_i = 1'b0;

    // refill with id 2 (ptr 3 -> scan 3,0,1,2)
    v_i = 4'b0100;
    #1 chk("refill_yumi", {28'd0, yumi_o}, 32'h4);
    tick();
    chk_out("refill", 1'b1, 16'h1234, 2'd2);

    // reset mid-operation with requester 3 pending
    reset_n = 1'b0;
    v_i     = 4'b1000;
    #1 chk("midrst_yumi", {28'd0, yumi_o}, 32'h0);
    tick();
    chk_out("midrst", 1'b0, 16'h0000, 2'd0);

    // after release, requester 3 wins from ptr 0
    reset_n = 1'b1;
    #1 chk("post_yumi", {28'd0, yumi_o}, 32'h8);
    tick();
    chk_out("post", 1'b1, 16'h00A3, 2'd3);

    // ptr wrapped to 0: scan 0,1 -> requester 1, then 2,3 -> requester 3
    v_i    = 4'b1010;
    yumi_i = 1'b1;
    #1 chk("wrap1_yumi", {28'd0, yumi_o}, 32'h2);
    tick();
    chk_out("wrap1", 1'b1, 16'h00A1, 2'd1);
    #1 chk("wrap2_yumi", {28'd0, yumi_o}, 32'h8);
    tick();
    chk_out("wrap2", 1'b1, 16'h00A3, 2'd3);

`ifdef BSG_DFF_ARB_LOCK_EN
    // ptr 0; locked requester 0 wins three times, unlocked fourth, then 1
    v_i = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      lock_i = (k < 3) ? 4'b0001 : 4'b0000;
      #1 chk("lock_yumi", {28'd0, yumi_o}, (k < 4) ? 32'h1 : 32'h2);
      tick();
      chk_out("lock", 1'b1, (k < 4) ? 16'h00A0 : 16'h00A1, (k < 4) ? 2'd0 : 2'd1);
    end
    lock_i = 4'b0000;
`endif

    // final drain
    v_i = 4'b0000;
    tick();
    chk_out("final", 1'b0, v_o ? 16'hFFFF : data_o, id_o);
    yumi_i = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
